// File: rtl/tx_2de5_serial_if.sv
// Handshake and serial-line bundle for tx_2de5_serial.
// Define TX_2DE5_PAR_EN to add the parallel E1..E5/code_strobe echo signals.
interface tx_2de5_serial_if;
    logic [3:0] digit;
    logic       digit_valid;
    logic       digit_ready;
    logic       tx_data;
    logic       tx_frame;
    logic       err;
`ifdef TX_2DE5_PAR_EN
    logic       E1;
    logic       E2;
    logic       E3;
    logic       E4;
    logic       E5;
    logic       code_strobe;

    modport master (
        output digit,
        output digit_valid,
        input  digit_ready,
        input  tx_data,
        input  tx_frame,
        input  err,
        input  E1,
        input  E2,
        input  E3,
        input  E4,
        input  E5,
        input  code_strobe
    );

    modport slave (
        input  digit,
        input  digit_valid,
        output digit_ready,
        output tx_data,
        output tx_frame,
        output err,
        output E1,
        output E2,
        output E3,
        output E4,
        output E5,
        output code_strobe
    );
`else
    modport master (
        output digit,
        output digit_valid,
        input  digit_ready,
        input  tx_data,
        input  tx_frame,
        input  err
    );

    modport slave (
        input  digit,
        input  digit_valid,
        output digit_ready,
        output tx_data,
        output tx_frame,
        output err
    );
`endif
endinterface

// File: rtl/tx_2de5_serial.sv
// 2-of-5 serial transmitter: one BCD digit per handshake, shifted out E1 first.
// Define TX_2DE5_PAR_EN to add registered parallel outputs E1..E5 and code_strobe.
module tx_2de5_serial #(
    parameter int CLKS_PER_BIT = 4,
    parameter int GAP_BITS     = 1
) (
    input  logic                clk,
    input  logic                rst,
    tx_2de5_serial_if.slave     bus
);

    localparam int GAP_CYC = GAP_BITS * CLKS_PER_BIT;
    localparam int BIT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CLKS_PER_BIT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t             state_reg,   state_next;
    logic [4:0]         shift_reg,   shift_next;
    logic [BIT_W-1:0]   bit_cnt_reg, bit_cnt_next;
    logic [2:0]         bit_idx_reg, bit_idx_next;
    logic [GAP_W-1:0]   gap_cnt_reg, gap_cnt_next;
    logic               ready_reg,   ready_next;
    logic               frame_reg,   frame_next;
    logic               err_reg,     err_next;
`ifdef TX_2DE5_PAR_EN
    logic [4:0]         code_reg,    code_next;
    logic               strobe_reg,  strobe_next;
`endif

    logic [4:0]         word;
    logic               is_bcd;
    logic               handshake;

    // Code map E1..E5 (weights 7,4,2,1,0); word[4] is E1 and goes out first.
    always_comb begin
        word   = 5'b00000;
        is_bcd = 1'b1;
        case (bus.digit)
            4'd0:    word = 5'b11000;
            4'd1:    word = 5'b00011;
            4'd2:    word = 5'b00101;
            4'd3:    word = 5'b00110;
            4'd4:    word = 5'b01001;
            4'd5:    word = 5'b01010;
            4'd6:    word = 5'b01100;
            4'd7:    word = 5'b10001;
            4'd8:    word = 5'b10010;
            4'd9:    word = 5'b10100;
            default: is_bcd = 1'b0;
        endcase
    end

    assign handshake = bus.digit_valid && ready_reg;

    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt_reg;
        bit_idx_next = bit_idx_reg;
        gap_cnt_next = gap_cnt_reg;
        ready_next   = ready_reg;
        frame_next   = frame_reg;
        err_next     = 1'b0;
`ifdef TX_2DE5_PAR_EN
        code_next    = code_reg;
        strobe_next  = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (handshake) begin
                    if (is_bcd) begin
                        state_next   = SEND;
                        shift_next   = word;
                        bit_cnt_next = '0;
                        bit_idx_next = 3'd0;
                        ready_next   = 1'b0;
                        frame_next   = 1'b1;
`ifdef TX_2DE5_PAR_EN
                        code_next    = word;
                        strobe_next  = 1'b1;
`endif
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            SEND: begin
                if (bit_cnt_reg == BIT_LAST) begin
                    // After five shifts the register is all zeros, so tx_data idles low.
                    bit_cnt_next = '0;
                    shift_next   = {shift_reg[3:0], 1'b0};
                    bit_idx_next = bit_idx_reg + 3'd1;
                    if (bit_idx_reg == 3'd4) begin
                        bit_idx_next = 3'd0;
                        frame_next   = 1'b0;
                        if (GAP_CYC == 0) begin
                            state_next = IDLE;
                            ready_next = 1'b1;
                        end else begin
                            state_next   = GAP;
                            gap_cnt_next = '0;
                        end
                    end
                end else begin
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt_reg == GAP_LAST) begin
                    state_next   = IDLE;
                    ready_next   = 1'b1;
                    gap_cnt_next = '0;
                end else begin
                    gap_cnt_next = gap_cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                ready_next = 1'b1;
                frame_next = 1'b0;
                shift_next = 5'b00000;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            shift_reg   <= 5'b00000;
            bit_cnt_reg <= '0;
            bit_idx_reg <= 3'd0;
            gap_cnt_reg <= '0;
            ready_reg   <= 1'b1;
            frame_reg   <= 1'b0;
            err_reg     <= 1'b0;
`ifdef TX_2DE5_PAR_EN
            code_reg    <= 5'b00000;
            strobe_reg  <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_next;
            bit_idx_reg <= bit_idx_next;
            gap_cnt_reg <= gap_cnt_next;
            ready_reg   <= ready_next;
            frame_reg   <= frame_next;
            err_reg     <= err_next;
`ifdef TX_2DE5_PAR_EN
            code_reg    <= code_next;
            strobe_reg  <= strobe_next;
`endif
        end
    end

    assign bus.digit_ready = ready_reg;
    assign bus.tx_data     = shift_reg[4];
    assign bus.tx_frame    = frame_reg;
    assign bus.err         = err_reg;
`ifdef TX_2DE5_PAR_EN
    assign bus.E1          = code_reg[4];
    assign bus.E2          = code_reg[3];
    assign bus.E3          = code_reg[2];
    assign bus.E4          = code_reg[1];
    assign bus.E5          = code_reg[0];
    assign bus.code_strobe = strobe_reg;
`endif

endmodule
